fetch_unit: RTL

- Instruction-fetch front end for the multi-cycle ISA controller `fms`.
- Holds PC and IR, prefetches mem[PC] into a one-entry buffer over a req/ack memory handshake, and executes the controller's enPC/enIR strobes.
- Drives the 2-bit opcode `x` that the controller decodes, plus operand fields to the datapath.
- Sits directly upstream of `fms` and of the ROP/RIO register enables.

---
 rtl/isa_pkg.sv | 24 ++
 rtl/pc_reg.sv | 37 +++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA constants for the fetch front end and the fms controller.
package isa_pkg;

  localparam int OPW  = 2;
  localparam int REGW = 2;

  localparam logic [OPW-1:0] OPC_0 = 2'd0;
  localparam logic [OPW-1:0] OPC_1 = 2'd1;
  localparam logic [OPW-1:0] OPC_2 = 2'd2;
  localparam logic [OPW-1:0] OPC_3 = 2'd3;

  // Field MSB offsets counted down from IR[IW-1]; imm runs from its MSB to bit 0.
  localparam int OPC_MSB_OFS = 0;
  localparam int DST_MSB_OFS = OPW;
  localparam int SRC_MSB_OFS = OPW + REGW;
  localparam int IMM_MSB_OFS = OPW + 2 * REGW;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_BUSY  = 2'd1,
    FS_STALE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter: load has priority over increment, increment wraps mod 2^AW.
module pc_reg #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [AW-1:0] target_i,
  input  logic          inc_i,
  output logic [AW-1:0] pc_o,
  output logic          change_o
);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      pc_d = pc_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o     = pc_q;
  assign change_o = load_i | inc_i;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, one-entry prefetch buffer over req/ack, IR and operand decode.
module fetch_unit
  import isa_pkg::*;
#(
  parameter int AW = 8,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enPC,
  input  logic          enIR,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_target,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  output logic [1:0]    x,
  output logic [1:0]    dst,
  output logic [1:0]    src,
  output logic [IW-7:0] imm,
  output logic [AW-1:0] pc,
  output logic          stall
);

  fetch_state_e  state_q, state_d;
  logic [IW-1:0] fb_q, fb_d;
  logic          fb_valid_q, fb_valid_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          pending_q, pending_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic          pc_change;
  logic          ack_busy;
  logic          bypass;

  pc_reg #(.AW(AW)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (pc_load),
    .target_i (pc_target),
    .inc_i    (enPC),
    .pc_o     (pc),
    .change_o (pc_change)
  );

  assign ack_busy = (state_q == FS_BUSY) && imem_ack;
  assign bypass   = ack_busy && (pending_q || enIR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A request issued while the PC moves already targets a dead address.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_IDLE: begin
        if (!fb_valid_q) begin
          state_d = pc_change ? FS_STALE : FS_BUSY;
        end
      end
      FS_BUSY: begin
        if (imem_ack) begin
          state_d = FS_IDLE;
        end else if (pc_change) begin
          state_d = FS_STALE;
        end
      end
      FS_STALE: begin
        if (imem_ack) begin
          state_d = FS_IDLE;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  // Request is gated by rst_n so it drops immediately when reset asserts.
  always_comb begin
    imem_req  = 1'b1;
    imem_addr = req_addr_q;
    if (state_q == FS_IDLE) begin
      imem_req  = rst_n & ~fb_valid_q;
      imem_addr = pc;
    end
  end

  always_comb begin
    req_addr_d = req_addr_q;
    if (state_q == FS_IDLE && !fb_valid_q) begin
      req_addr_d = pc;
    end

    fb_d       = fb_q;
    fb_valid_d = fb_valid_q;
    if (pc_change) begin
      fb_valid_d = 1'b0;
    end else if (ack_busy) begin
      fb_d       = imem_data;
      fb_valid_d = 1'b1;
    end

    ir_d      = ir_q;
    pending_d = pending_q;
    if (bypass) begin
      ir_d      = imem_data;
      pending_d = 1'b0;
    end else if (enIR && fb_valid_q) begin
      ir_d = fb_q;
    end else if (enIR) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_q       <= '0;
      fb_valid_q <= 1'b0;
      ir_q       <= '0;
      pending_q  <= 1'b0;
      req_addr_q <= '0;
    end else begin
      fb_q       <= fb_d;
      fb_valid_q <= fb_valid_d;
      ir_q       <= ir_d;
      pending_q  <= pending_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign stall = pending_q | (enIR & ~fb_valid_q);
  assign x     = ir_q[IW-1-OPC_MSB_OFS -: OPW];
  assign dst   = ir_q[IW-1-DST_MSB_OFS -: REGW];
  assign src   = ir_q[IW-1-SRC_MSB_OFS -: REGW];
  assign imm   = ir_q[IW-1-IMM_MSB_OFS:0];

endmodule
